pipeline_ctrl: RTL and testbench

Sequencing controller for the three-stage (IF / EXE / MWB) RISC-V pipeline. Forwarding covers ALU/LUI results only. This block owns:
- the boot sequence;
- load-use stalls;
- branch/jump redirects and flushes;
- instruction- and data-memory wait freezes.

It drives the hold/bubble controls of the IF→EXE and EXE→MWB pipeline registers and the PC mux. It keeps saturating stall/flush counters for CSR readout.

---
 rtl/pipeline_ctrl_pkg.sv | 47 ++++
 rtl/pipeline_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the three-stage pipeline sequencing controller:
// RV32I opcodes, controller state encodings, PC-mux selects and the NOP word.
package pipeline_ctrl_pkg;

   // RV32I major opcodes (inst[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;

   // Controller states
   localparam logic [1:0] ST_BOOT       = 2'd0;
   localparam logic [1:0] ST_RUN        = 2'd1;
   localparam logic [1:0] ST_LOAD_STALL = 2'd2;
   localparam logic [1:0] ST_DMEM_WAIT  = 2'd3;

   // PC mux selects
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_RESET  = 2'd2;
   localparam logic [1:0] PC_HOLD   = 2'd3;

   // addi x0,x0,0 -- what the datapath loads into a bubbled stage
   localparam logic [31:0] INST_NOP = 32'h00000013;

   // Register-specifier fields used by hazard detection
   typedef struct packed {
      logic [6:0] opcode;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } inst_fields_t;

   function automatic inst_fields_t decode_fields(input logic [31:0] inst);
      inst_fields_t f;
      f.opcode = inst[6:0];
      f.rd     = inst[11:7];
      f.rs1    = inst[19:15];
      f.rs2    = inst[24:20];
      return f;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes precedence.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   // Count events, sticking at all-ones; clear overrides an increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + ONE;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Sequencing controller for the IF / EXE / MWB pipeline: boot, load-use
// stalls, branch/jump redirects and memory-wait freezes. Outputs are Mealy
// decodes of the current state and the instructions sitting in EXE and MWB.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      inst_EXE,
   input  logic [31:0]      inst_MWB,
   input  logic             branch_taken_EXE,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             cnt_clr,
   output logic [1:0]       pc_sel,
   output logic             stall_IF,
   output logic             stall_EXE,
   output logic             stall_MWB,
   output logic             bubble_EXE,
   output logic             bubble_MWB,
   output logic             dmem_valid,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [1:0]       state_o
);

   inst_fields_t f_exe;
   inst_fields_t f_mwb;
   logic         lu;
   logic         redir;
   logic         freeze;
   logic         hold_mem;
   logic         flush_inc;
   logic         stall_inc;
   logic [1:0]   state;
   logic [1:0]   next_state;

   // Hazard decode: load-use against MWB's load, redirects resolved in EXE,
   // and the data-memory freeze. Forwarding only covers ALU/LUI results, so a
   // loaded value must wait one cycle before EXE may consume it.
   always_comb begin
      f_exe      = decode_fields(inst_EXE);
      f_mwb      = decode_fields(inst_MWB);
      dmem_valid = (f_mwb.opcode == OP_LOAD) || (f_mwb.opcode == OP_STORE);
      freeze     = dmem_valid && !dmem_ready;
      lu         = (f_mwb.opcode == OP_LOAD) && (f_mwb.rd != 5'd0) &&
                   (((f_exe.rs1 == f_mwb.rd) &&
                     (f_exe.opcode != OP_LUI) && (f_exe.opcode != OP_AUIPC) &&
                     (f_exe.opcode != OP_JAL)) ||
                    ((f_exe.rs2 == f_mwb.rd) &&
                     ((f_exe.opcode == OP_BRANCH) || (f_exe.opcode == OP_STORE) ||
                      (f_exe.opcode == OP_RTYPE))));
      redir      = (f_exe.opcode == OP_JAL) || (f_exe.opcode == OP_JALR) ||
                   ((f_exe.opcode == OP_BRANCH) && branch_taken_EXE);
      // In DMEM_WAIT the access is still outstanding until dmem_ready rises
      hold_mem   = (state == ST_DMEM_WAIT) ? !dmem_ready : freeze;
   end

   // Prioritised pipeline control and next-state selection
   always_comb begin
      pc_sel     = PC_PLUS4;
      stall_IF   = 1'b0;
      stall_EXE  = 1'b0;
      stall_MWB  = 1'b0;
      bubble_EXE = 1'b0;
      bubble_MWB = 1'b0;
      flush_inc  = 1'b0;
      next_state = ST_RUN;
      if (state == ST_BOOT) begin
         pc_sel     = PC_RESET;
         stall_IF   = 1'b1;
         bubble_EXE = 1'b1;
         bubble_MWB = 1'b1;
      end else if (hold_mem) begin
         // Whole pipeline freezes behind the data-memory access
         pc_sel     = PC_HOLD;
         stall_IF   = 1'b1;
         stall_EXE  = 1'b1;
         stall_MWB  = 1'b1;
         next_state = ST_DMEM_WAIT;
      end else if (lu) begin
         // Hold IF/EXE, let the load retire, and slip a bubble into MWB.
         // A redirect in EXE is re-evaluated next cycle with the loaded value.
         pc_sel     = PC_HOLD;
         stall_IF   = 1'b1;
         stall_EXE  = 1'b1;
         bubble_MWB = 1'b1;
         next_state = ST_LOAD_STALL;
      end else if (redir) begin
         // Redirect also discards any fetch still pending from IMEM
         pc_sel     = PC_TARGET;
         bubble_EXE = 1'b1;
         flush_inc  = 1'b1;
      end else if (!imem_ready) begin
         pc_sel     = PC_HOLD;
         stall_IF   = 1'b1;
         bubble_EXE = 1'b1;
      end
   end

   // Controller state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_BOOT;
      else
         state <= next_state;
   end

   assign state_o   = state;
   assign stall_inc = stall_IF && (state != ST_BOOT);

   // Cycles spent with the front end held (boot cycle excluded)
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .clr   (cnt_clr),
      .count (stall_count)
   );

   // Redirects taken
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .clr   (cnt_clr),
      .count (flush_count)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle RUN-state decodes
// plus hand-written multi-cycle sequences. A second instance with a 4-bit
// counter width covers saturation.
module tb_pipeline_ctrl;

   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] LW_X5    = 32'h0000A283; // lw   x5,0(x1)
   localparam logic [31:0] LW_X0    = 32'h0000A003; // lw   x0,0(x1)
   localparam logic [31:0] ADD_RS1  = 32'h00728333; // add  x6,x5,x7
   localparam logic [31:0] ADD_X0   = 32'h00700333; // add  x6,x0,x7
   localparam logic [31:0] ADD_RS2  = 32'h00538333; // add  x6,x7,x5
   localparam logic [31:0] ADDI_IMM = 32'h00538313; // addi x6,x7,5
   localparam logic [31:0] LUI_X5F  = 32'h00028337; // lui with bits[19:15]=5
   localparam logic [31:0] JAL      = 32'h000000EF; // jal  x1,0
   localparam logic [31:0] BEQ      = 32'h00000063; // beq  x0,x0,0
   localparam logic [31:0] BEQ_X5   = 32'h00028063; // beq  x5,x0,0
   localparam logic [31:0] JALR_X5  = 32'h00028067; // jalr x0,0(x5)
   localparam logic [31:0] SW_X5    = 32'h0050A023; // sw   x5,0(x1)

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_EXE;
   logic [31:0] inst_MWB;
   logic        branch_taken_EXE;
   logic        imem_ready;
   logic        dmem_ready;
   logic        cnt_clr;

   logic [1:0]  pc_sel;
   logic        stall_IF, stall_EXE, stall_MWB, bubble_EXE, bubble_MWB, dmem_valid;
   logic [31:0] stall_count, flush_count;
   logic [1:0]  state_o;

   logic [1:0]  pc_sel_4;
   logic        stall_IF_4, stall_EXE_4, stall_MWB_4, bubble_EXE_4, bubble_MWB_4, dmem_valid_4;
   logic [3:0]  stall_count_4, flush_count_4;
   logic [1:0]  state_4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .inst_EXE         (inst_EXE),
      .inst_MWB         (inst_MWB),
      .branch_taken_EXE (branch_taken_EXE),
      .imem_ready       (imem_ready),
      .dmem_ready       (dmem_ready),
      .cnt_clr          (cnt_clr),
      .pc_sel           (pc_sel),
      .stall_IF         (stall_IF),
      .stall_EXE        (stall_EXE),
      .stall_MWB        (stall_MWB),
      .bubble_EXE       (bubble_EXE),
      .bubble_MWB       (bubble_MWB),
      .dmem_valid       (dmem_valid),
      .stall_count      (stall_count),
      .flush_count      (flush_count),
      .state_o          (state_o)
   );

   pipeline_ctrl #(.CNT_W(4)) dut4 (
      .clk              (clk),
      .rst_n            (rst_n),
      .inst_EXE         (inst_EXE),
      .inst_MWB         (inst_MWB),
      .branch_taken_EXE (branch_taken_EXE),
      .imem_ready       (imem_ready),
      .dmem_ready       (dmem_ready),
      .cnt_clr          (cnt_clr),
      .pc_sel           (pc_sel_4),
      .stall_IF         (stall_IF_4),
      .stall_EXE        (stall_EXE_4),
      .stall_MWB        (stall_MWB_4),
      .bubble_EXE       (bubble_EXE_4),
      .bubble_MWB       (bubble_MWB_4),
      .dmem_valid       (dmem_valid_4),
      .stall_count      (stall_count_4),
      .flush_count      (flush_count_4),
      .state_o          (state_4)
   );

   typedef struct {
      logic [31:0] exe;
      logic [31:0] mwb;
      logic        br;
      logic        imem;
      logic        dmem;
      logic [1:0]  pc;
      logic        s_if;
      logic        s_exe;
      logic        s_mwb;
      logic        b_exe;
      logic        b_mwb;
      logic        dv;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      inst_EXE         = NOP;
      inst_MWB         = NOP;
      branch_taken_EXE = 1'b0;
      imem_ready       = 1'b1;
      dmem_ready       = 1'b1;
      cnt_clr          = 1'b0;
   endtask

   task automatic clear_counters();
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   initial begin
      //                exe       mwb    br imem dmem pc  sIF sEX sMW bEX bMW dv
      vecs[0]  = '{NOP,      NOP,    0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{ADD_RS1,  LW_X5,  0, 1, 1, 2'd3, 1, 1, 0, 0, 1, 1};
      vecs[2]  = '{ADD_X0,   LW_X0,  0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 1};
      vecs[3]  = '{ADD_RS2,  LW_X5,  0, 1, 1, 2'd3, 1, 1, 0, 0, 1, 1};
      vecs[4]  = '{ADDI_IMM, LW_X5,  0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 1};
      vecs[5]  = '{LUI_X5F,  LW_X5,  0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 1};
      vecs[6]  = '{JAL,      NOP,    0, 0, 1, 2'd1, 0, 0, 0, 1, 0, 0};
      vecs[7]  = '{BEQ,      NOP,    1, 1, 1, 2'd1, 0, 0, 0, 1, 0, 0};
      vecs[8]  = '{BEQ,      NOP,    0, 0, 1, 2'd3, 1, 0, 0, 1, 0, 0};
      vecs[9]  = '{JAL,      SW_X5,  0, 1, 0, 2'd3, 1, 1, 1, 0, 0, 1};
      vecs[10] = '{BEQ_X5,   LW_X5,  1, 1, 1, 2'd3, 1, 1, 0, 0, 1, 1};
      vecs[11] = '{JALR_X5,  LW_X5,  0, 1, 1, 2'd3, 1, 1, 0, 0, 1, 1};
      vecs[12] = '{SW_X5,    LW_X5,  0, 1, 1, 2'd3, 1, 1, 0, 0, 1, 1};

      // Reset and boot
      idle();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst pc_sel", 32'(pc_sel), 32'd2);
      check("rst stall_IF", 32'(stall_IF), 32'd1);
      check("rst bubble_EXE", 32'(bubble_EXE), 32'd1);
      check("rst bubble_MWB", 32'(bubble_MWB), 32'd1);
      check("rst stall_EXE", 32'(stall_EXE), 32'd0);
      check("rst stall_MWB", 32'(stall_MWB), 32'd0);
      check("rst dmem_valid", 32'(dmem_valid), 32'd0);
      check("rst state", 32'(state_o), 32'd0);
      check("rst stall_count", stall_count, 32'd0);
      check("rst flush_count", flush_count, 32'd0);
      rst_n = 1'b1;
      #1;
      check("boot state", 32'(state_o), 32'd0);
      check("boot pc_sel", 32'(pc_sel), 32'd2);
      @(negedge clk);
      #1;
      check("run state", 32'(state_o), 32'd1);
      check("run pc_sel", 32'(pc_sel), 32'd0);
      check("boot not counted", stall_count, 32'd0);

      // Table of single-cycle decodes in RUN; idle inputs before each edge
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         inst_EXE         = vecs[i].exe;
         inst_MWB         = vecs[i].mwb;
         branch_taken_EXE = vecs[i].br;
         imem_ready       = vecs[i].imem;
         dmem_ready       = vecs[i].dmem;
         #1;
         check($sformatf("v%0d state", i), 32'(state_o), 32'd1);
         check($sformatf("v%0d pc_sel", i), 32'(pc_sel), 32'(vecs[i].pc));
         check($sformatf("v%0d stall_IF", i), 32'(stall_IF), 32'(vecs[i].s_if));
         check($sformatf("v%0d stall_EXE", i), 32'(stall_EXE), 32'(vecs[i].s_exe));
         check($sformatf("v%0d stall_MWB", i), 32'(stall_MWB), 32'(vecs[i].s_mwb));
         check($sformatf("v%0d bubble_EXE", i), 32'(bubble_EXE), 32'(vecs[i].b_exe));
         check($sformatf("v%0d bubble_MWB", i), 32'(bubble_MWB), 32'(vecs[i].b_mwb));
         check($sformatf("v%0d dmem_valid", i), 32'(dmem_valid), 32'(vecs[i].dv));
         idle();
      end

      // Load-use: one-cycle stall, then clean LOAD_STALL cycle
      clear_counters();
      inst_MWB = LW_X5;
      inst_EXE = ADD_RS1;
      #1;
      check("lu stall_IF", 32'(stall_IF), 32'd1);
      check("lu stall_EXE", 32'(stall_EXE), 32'd1);
      check("lu bubble_MWB", 32'(bubble_MWB), 32'd1);
      check("lu pc_sel", 32'(pc_sel), 32'd3);
      @(negedge clk);
      inst_MWB = NOP;
      #1;
      check("lu2 state", 32'(state_o), 32'd2);
      check("lu2 pc_sel", 32'(pc_sel), 32'd0);
      check("lu2 stall_IF", 32'(stall_IF), 32'd0);
      check("lu2 stall_EXE", 32'(stall_EXE), 32'd0);
      check("lu2 bubble_MWB", 32'(bubble_MWB), 32'd0);
      check("lu2 stall_count", stall_count, 32'd1);
      idle();
      @(negedge clk);
      #1;
      check("lu3 state", 32'(state_o), 32'd1);

      // Branch taken while IMEM not ready: redirect wins
      clear_counters();
      inst_EXE         = BEQ;
      branch_taken_EXE = 1'b1;
      imem_ready       = 1'b0;
      #1;
      check("br pc_sel", 32'(pc_sel), 32'd1);
      check("br bubble_EXE", 32'(bubble_EXE), 32'd1);
      check("br stall_IF", 32'(stall_IF), 32'd0);
      @(negedge clk);
      idle();
      #1;
      check("br flush_count", flush_count, 32'd1);
      check("br stall_count", stall_count, 32'd0);

      // DMEM wait of 3 cycles with a taken branch waiting in EXE
      clear_counters();
      inst_MWB         = SW_X5;
      inst_EXE         = BEQ;
      branch_taken_EXE = 1'b1;
      dmem_ready       = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("dw%0d stall_IF", k), 32'(stall_IF), 32'd1);
         check($sformatf("dw%0d stall_EXE", k), 32'(stall_EXE), 32'd1);
         check($sformatf("dw%0d stall_MWB", k), 32'(stall_MWB), 32'd1);
         check($sformatf("dw%0d pc_sel", k), 32'(pc_sel), 32'd3);
         check($sformatf("dw%0d bubble_EXE", k), 32'(bubble_EXE), 32'd0);
         @(negedge clk);
      end
      dmem_ready = 1'b1;
      #1;
      check("dw rel state", 32'(state_o), 32'd3);
      check("dw rel pc_sel", 32'(pc_sel), 32'd1);
      check("dw rel bubble_EXE", 32'(bubble_EXE), 32'd1);
      check("dw rel stall_MWB", 32'(stall_MWB), 32'd0);
      check("dw rel stall_count", stall_count, 32'd3);
      @(negedge clk);
      idle();
      #1;
      check("dw post flush_count", flush_count, 32'd1);
      check("dw post stall_count", stall_count, 32'd3);
      check("dw post state", 32'(state_o), 32'd1);

      // Saturation at 4 bits, then clear racing a stall
      clear_counters();
      imem_ready = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("sat cnt4", 32'(stall_count_4), 32'd15);
      check("sat cnt32", stall_count, 32'd20);
      cnt_clr = 1'b1;
      @(negedge clk);
      #1;
      check("clr cnt4", 32'(stall_count_4), 32'd0);
      check("clr cnt32", stall_count, 32'd0);
      cnt_clr = 1'b0;
      @(negedge clk);
      #1;
      check("post clr cnt4", 32'(stall_count_4), 32'd1);
      idle();

      // Reset asserted mid DMEM wait
      @(negedge clk);
      inst_MWB   = SW_X5;
      dmem_ready = 1'b0;
      @(negedge clk);
      #1;
      check("mid state", 32'(state_o), 32'd3);
      check("mid stall_count", stall_count, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid rst state", 32'(state_o), 32'd0);
      check("mid rst pc_sel", 32'(pc_sel), 32'd2);
      check("mid rst stall_EXE", 32'(stall_EXE), 32'd0);
      check("mid rst stall_MWB", 32'(stall_MWB), 32'd0);
      check("mid rst bubble_MWB", 32'(bubble_MWB), 32'd1);
      check("mid rst stall_count", stall_count, 32'd0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("reboot state", 32'(state_o), 32'd1);
      check("reboot stall_count", stall_count, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
